gate_sweep_checker: RTL and testbench

- Synthesizable stimulus-and-response engine for the gate-level cells of the NanoRisc datapath (and, or, xor, ...).
- Drives every input combination of an N-input combinational cell, waits a settle time, samples the cell output and compares it against a truth-table parameter.
- Reports pass/fail, an error count and the first failing vector.
- Used as a built-in self test beside the datapath and as the reusable checker end of the cell benches.

---
 rtl/gate_check_pkg.sv | 17 +
 rtl/settle_counter.sv | 28 ++
 rtl/gate_sweep_checker.sv | 122 ++++++++++++
 tb/tb_gate_sweep_checker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// Shared state encoding and truth-table constants for the gate-cell sweep checker.
package gate_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Bit i is the expected cell output for input vector i.
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;

endpackage

// File: rtl/settle_counter.sv
// Counts settle cycles while a vector is driven; expire_c flags the last settle cycle.
module settle_counter #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (load) begin
      wait_cnt <= '0;
    end else if (en) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign expire_c = (wait_cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive input sweep of an N-input combinational cell, scored against a truth table.
module gate_sweep_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned           N_IN     = 2,
  parameter int unsigned           SETTLE   = 1,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED = TT_AND2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_valid
);

  localparam int unsigned NV = 1 << N_IN;
  localparam int unsigned IW = N_IN + 1;

  state_e          state, state_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [IW-1:0]   err_nx;
  logic [N_IN-1:0] ff_nx;
  logic [N_IN-1:0] dut_in_nx;
  logic            fv_nx, pass_nx, busy_nx, done_nx;
  logic            expire_c, last_c, mismatch_c, settle_load_c, settle_en_c;

  assign last_c        = (idx == IW'(NV - 1));
  assign mismatch_c    = (dut_out != EXPECTED[idx[N_IN-1:0]]);
  assign settle_load_c = (state_nx == ST_DRIVE) && (state != ST_DRIVE);
  assign settle_en_c   = (state == ST_DRIVE);

  settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (settle_load_c),
    .en       (settle_en_c),
    .expire_c (expire_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_DRIVE;
      ST_DRIVE:  if (expire_c) state_nx = ST_SAMPLE;
      ST_SAMPLE: state_nx = last_c ? ST_DONE : ST_DRIVE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Next values for the vector counter, score and registered outputs
  always_comb begin
    idx_nx  = idx;
    err_nx  = err_count;
    ff_nx   = first_fail;
    fv_nx   = fail_valid;
    pass_nx = pass;
    case (state)
      ST_IDLE: begin
        if (start) begin
          idx_nx  = '0;
          err_nx  = '0;
          ff_nx   = '0;
          fv_nx   = 1'b0;
          pass_nx = 1'b0;
        end
      end
      ST_SAMPLE: begin
        if (mismatch_c) begin
          err_nx = err_count + IW'(1);
          if (!fail_valid) begin
            ff_nx = idx[N_IN-1:0];
            fv_nx = 1'b1;
          end
        end
        if (!last_c) idx_nx = idx + IW'(1);
      end
      default: ;
    endcase
    // Verdict captured with the final vector's score folded in
    if ((state_nx == ST_DONE) && (state != ST_DONE)) pass_nx = (err_nx == '0);
    dut_in_nx = ((state_nx == ST_DRIVE) || (state_nx == ST_SAMPLE)) ? idx_nx[N_IN-1:0] : '0;
    busy_nx   = (state_nx != ST_IDLE);
    done_nx   = (state_nx == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
      pass       <= 1'b0;
      dut_in     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      idx        <= idx_nx;
      err_count  <= err_nx;
      first_fail <= ff_nx;
      fail_valid <= fv_nx;
      pass       <= pass_nx;
      dut_in     <= dut_in_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: 2-input/SETTLE=1 checker and 3-input/SETTLE=3 checker driving modelled cells.
module tb_gate_sweep_checker;
  import gate_check_pkg::*;

  logic       clk, rst_n;
  logic       start_a, start_b;
  logic [1:0] dut_in_a;
  logic [2:0] dut_in_b;
  logic       dut_out_a, dut_out_b;
  logic       busy_a, done_a, pass_a, fail_valid_a;
  logic       busy_b, done_b, pass_b, fail_valid_b;
  logic [2:0] err_count_a;
  logic [3:0] err_count_b;
  logic [1:0] first_fail_a;
  logic [2:0] first_fail_b;
  logic [1:0] mode_a;
  logic       mode_b;

  int n_vec = 0;
  int n_err = 0;

  gate_sweep_checker #(.N_IN(2), .SETTLE(1), .EXPECTED(TT_AND2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_count_a),
    .first_fail(first_fail_a), .fail_valid(fail_valid_a)
  );

  gate_sweep_checker #(.N_IN(3), .SETTLE(3), .EXPECTED(8'h80)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_count_b),
    .first_fail(first_fail_b), .fail_valid(fail_valid_b)
  );

  // Cell models: 0 AND2, 1 stuck-at-0, 2 OR2, 3 inverted AND2
  always_comb begin
    case (mode_a)
      2'd0:    dut_out_a = dut_in_a[0] & dut_in_a[1];
      2'd1:    dut_out_a = 1'b0;
      2'd2:    dut_out_a = dut_in_a[0] | dut_in_a[1];
      default: dut_out_a = ~(dut_in_a[0] & dut_in_a[1]);
    endcase
    dut_out_b = mode_b ? ~(&dut_in_b) : (&dut_in_b);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on one checker and check the edge at which done first rises.
  task automatic do_sweep(input bit inst, input int exp_edges, input string tag);
    int  edges;
    bit  seen;
    if (inst) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    check({tag, "_busy"}, inst ? busy_b : busy_a, 1);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 200) begin
      tick();
      edges++;
      if (inst ? done_b : done_a) seen = 1'b1;
    end
    check({tag, "_done_edge"}, edges, exp_edges);
  endtask

  initial begin
    int pulses;
    int done_edge;
    rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0; mode_a = 2'd0; mode_b = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dut_in", dut_in_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_err", err_count_a, 0);
    check("rst_fv", fail_valid_a, 0);
    rst_n = 1'b1;
    tick();

    // Clean AND2 sweep with per-edge stimulus check
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("and_busy_e0", busy_a, 1);
    check("and_in_e0", dut_in_a, 0);
    for (int k = 1; k < 8; k++) begin
      tick();
      check($sformatf("and_in_e%0d", k), dut_in_a, k / 2);
    end
    tick();
    check("and_done", done_a, 1);
    check("and_pass", pass_a, 1);
    check("and_err", err_count_a, 0);
    check("and_fv", fail_valid_a, 0);
    tick();
    check("and_done_off", done_a, 0);
    check("and_busy_off", busy_a, 0);
    check("and_pass_hold", pass_a, 1);

    // Stuck-at-0 output
    mode_a = 2'd1;
    do_sweep(1'b0, 8, "sa0");
    check("sa0_err", err_count_a, 1);
    check("sa0_ff", first_fail_a, 3);
    check("sa0_fv", fail_valid_a, 1);
    check("sa0_pass", pass_a, 0);
    tick();

    // OR2 cell against the AND2 table, then a clean rerun clears the score
    mode_a = 2'd2;
    do_sweep(1'b0, 8, "or2");
    check("or2_err", err_count_a, 2);
    check("or2_ff", first_fail_a, 1);
    check("or2_pass", pass_a, 0);
    tick();
    mode_a = 2'd0;
    do_sweep(1'b0, 8, "rerun");
    check("rerun_pass", pass_a, 1);
    check("rerun_err", err_count_a, 0);
    check("rerun_fv", fail_valid_a, 0);
    tick();

    // Reset during vector 2
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) tick();
    check("mid_in", dut_in_a, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in", dut_in_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_err", err_count_a, 0);
    pulses = 0;
    repeat (3) begin
      tick();
      if (done_a) pulses++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done_a) pulses++;
    end
    check("mid_no_done", pulses, 0);
    do_sweep(1'b0, 8, "post_rst");
    check("post_rst_pass", pass_a, 1);
    tick();

    // start held high: one sweep, restart only after IDLE is reached
    start_a = 1'b1;
    tick();
    pulses = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (done_a) pulses++;
    end
    check("hold_idle_busy", busy_a, 0);
    tick();
    check("hold_restart_busy", busy_a, 1);
    start_a = 1'b0;
    check("hold_pulses", pulses, 1);
    pulses = 0;
    while (!done_a && pulses < 50) begin
      tick();
      pulses++;
    end
    check("hold_second_done", done_a, 1);
    tick();

    // AND3 with SETTLE=3: 4 cycles per vector, done at edge 32
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    done_edge = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 3) check("and3_in_e3", dut_in_b, 0);
      if (e == 4) check("and3_in_e4", dut_in_b, 1);
      if (done_b && done_edge == 0) done_edge = e;
    end
    check("and3_done_edge", done_edge, 32);
    check("and3_pass", pass_b, 1);
    check("and3_err", err_count_b, 0);

    mode_b = 1'b1;
    do_sweep(1'b1, 32, "inv3");
    check("inv3_err", err_count_b, 8);
    check("inv3_ff", first_fail_b, 0);
    check("inv3_fv", fail_valid_b, 1);
    check("inv3_pass", pass_b, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
